decode_stage: RTL and testbench

- Instruction-decode stage of the single-cycle MIPS processor.
- Holds the 32x32 general-purpose register file and the main control unit.
- Outputs the control word, both register operands, the shift amount and the extended immediate to the execute stage.
- Accepts write-back data (MemtoReg_Data) and commits it to the register file on the clock edge.

---
 rtl/decode_stage.sv | 96 +++++++++
 tb/tb_decode_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS decode stage: main control, immediate/shamt extract and 32x32 register file (optional REGFILE_BYPASS_EN write-through).
// Latency: reads and decode are combinational; write-back commits on the rising Clk edge.
// Backpressure: none, the single-cycle datapath accepts one instruction every cycle.
module decode_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [31:0]       Instruction,
    output logic [11:0]       ControlLines,
    input  logic [DATA_W-1:0] MemtoReg_Data,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] ImmediateField
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        dest;
    logic              reg_dst;
    logic              reg_write;
    logic              wr_en;
    logic [DATA_W-1:0] regs [REG_CNT];

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign shamt  = Instruction[10:6];

    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNE,Jump,ALUOp[2:0]}
    always_comb begin
        ControlLines = 12'b000000000_000;
        case (opcode)
            OP_RTYPE: ControlLines = 12'b100100000_010;
            OP_LW:    ControlLines = 12'b011110000_000;
            OP_SW:    ControlLines = 12'b010001000_000;
            OP_BEQ:   ControlLines = 12'b000000100_001;
            OP_BNE:   ControlLines = 12'b000000010_001;
            OP_ADDI:  ControlLines = 12'b010100000_000;
            OP_ANDI:  ControlLines = 12'b010100000_011;
            OP_ORI:   ControlLines = 12'b010100000_100;
            OP_SLTI:  ControlLines = 12'b010100000_101;
            OP_LUI:   ControlLines = 12'b010100000_110;
            OP_J:     ControlLines = 12'b000000001_000;
            default:  ControlLines = 12'b000000000_000;
        endcase
    end

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        if (opcode == OP_ANDI || opcode == OP_ORI)
            ImmediateField = {{(DATA_W-16){1'b0}}, Instruction[15:0]};
        else
            ImmediateField = {{(DATA_W-16){Instruction[15]}}, Instruction[15:0]};
    end

    assign reg_dst   = ControlLines[11];
    assign reg_write = ControlLines[8];
    assign dest      = reg_dst ? rd : rt;
    assign wr_en     = reg_write && (dest != 5'd0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < REG_CNT; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[dest] <= MemtoReg_Data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign ReadData1 = (rs == 5'd0) ? '0 : ((wr_en && dest == rs) ? MemtoReg_Data : regs[rs]);
    assign ReadData2 = (rt == 5'd0) ? '0 : ((wr_en && dest == rt) ? MemtoReg_Data : regs[rt]);
`else
    assign ReadData1 = (rs == 5'd0) ? '0 : regs[rs];
    assign ReadData2 = (rt == 5'd0) ? '0 : regs[rt];
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_decode_stage;

    typedef struct packed {
        logic [11:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  sh;
        logic [31:0] imm;
    } exp_t;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] Instruction = 32'h0;
    logic [31:0] MemtoReg_Data = 32'h0;
    logic [11:0] ControlLines;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  shamt;
    logic [31:0] ImmediateField;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_req = 1'b0;
    int    total = 0;
    int    bad = 0;

    decode_stage dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Instruction    (Instruction),
        .ControlLines   (ControlLines),
        .MemtoReg_Data  (MemtoReg_Data),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .shamt          (shamt),
        .ImmediateField (ImmediateField)
    );

    always #5 Clk = ~Clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the outputs are combinational, so the strobe marks when a vector is settled.
    always @(negedge Clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor.empty got=strobe want=queued_entry");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "ctrl", {20'h0, ControlLines}, {20'h0, e.ctrl});
                cmp(nm, "rd1",  ReadData1, e.rd1);
                cmp(nm, "rd2",  ReadData2, e.rd2);
                cmp(nm, "shamt", {27'h0, shamt}, {27'h0, e.sh});
                cmp(nm, "imm",  ImmediateField, e.imm);
            end
        end
    end

    // Drive one vector just after a rising edge; its write (if any) commits on the next edge.
    task automatic apply(input string nm, input logic rst, input logic [31:0] instr, input logic [31:0] wd,
                         input logic [11:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [4:0] sh, input logic [31:0] imm);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n         = rst;
        Instruction   = instr;
        MemtoReg_Data = wd;
        e = '{ctrl: ctrl, rd1: rd1, rd2: rd2, sh: sh, imm: imm};
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_req = 1'b1;
        @(negedge Clk);
        #1;
        chk_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge Clk);
        apply("in_reset",  1'b0, 32'h02324020, 32'h0000000A, 12'h902, 32'h0, 32'h0, 5'd0, 32'h00004020);
        apply("add_first", 1'b1, 32'h02324020, 32'h0000000A, 12'h902, 32'h0, 32'h0, 5'd0, 32'h00004020);
        apply("addi_r17",  1'b1, 32'h20110005, 32'h00000005, 12'h500, 32'h0,
              BYP ? 32'h5 : 32'h0, 5'd0, 32'h00000005);
        apply("addi_r18",  1'b1, 32'h20120007, 32'h00000007, 12'h500, 32'h0,
              BYP ? 32'h7 : 32'h0, 5'd0, 32'h00000007);
        apply("add_5_7",   1'b1, 32'h02324020, 32'h0000000C, 12'h902, 32'h5, 32'h7, 5'd0, 32'h00004020);
        apply("wr_zero",   1'b1, 32'h01110025, 32'hFFFFFFFF, 12'h902, 32'hC, 32'h5, 5'd0, 32'h00000025);
        apply("lw",        1'b1, 32'h8E29FFFC, 32'h12345678, 12'h780, 32'h5,
              BYP ? 32'h12345678 : 32'h0, 5'd31, 32'hFFFFFFFC);
        apply("ori",       1'b1, 32'h340A8001, 32'hA5A5A5A5, 12'h504, 32'h0,
              BYP ? 32'hA5A5A5A5 : 32'h0, 5'd0, 32'h00008001);
        apply("andi",      1'b1, 32'h312CF0F0, 32'h00000070, 12'h503, 32'h12345678,
              BYP ? 32'h70 : 32'h0, 5'd3, 32'h0000F0F0);
        apply("sw",        1'b1, 32'hAD8A0008, 32'hDEADBEEF, 12'h440, 32'h70, 32'hA5A5A5A5, 5'd0, 32'h00000008);
        apply("beq",       1'b1, 32'h114CFFFE, 32'hDEADBEEF, 12'h021, 32'hA5A5A5A5, 32'h70, 5'd31, 32'hFFFFFFFE);
        apply("bne",       1'b1, 32'h152A0010, 32'hDEADBEEF, 12'h011, 32'h12345678, 32'hA5A5A5A5, 5'd0, 32'h00000010);
        apply("jump",      1'b1, 32'h094A0000, 32'hDEADBEEF, 12'h008, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd0, 32'h0);
        apply("illegal",   1'b1, 32'hFD2C8000, 32'hDEADBEEF, 12'h000, 32'h12345678, 32'h70, 5'd0, 32'hFFFF8000);
        apply("no_change", 1'b1, 32'h014C0000, 32'h0,        12'h902, 32'hA5A5A5A5, 32'h70, 5'd0, 32'h0);
        apply("rs_zero",   1'b1, 32'h00090140, 32'h0,        12'h902, 32'h0, 32'h12345678, 5'd5, 32'h00000140);
        // Reset asserted mid-cycle: the check lands before any rising edge.
        apply("mid_reset", 1'b0, 32'h01090000, 32'h00000099, 12'h902, 32'h0, 32'h0, 5'd0, 32'h0);
        apply("rst_write", 1'b0, 32'h200D0033, 32'h00000033, 12'h500, 32'h0,
              BYP ? 32'h33 : 32'h0, 5'd0, 32'h00000033);
        apply("suppressed", 1'b1, 32'h01A80000, 32'h0,       12'h902, 32'h0, 32'h0, 5'd0, 32'h0);
        apply("post_write", 1'b1, 32'h200D0033, 32'h00000033, 12'h500, 32'h0,
              BYP ? 32'h33 : 32'h0, 5'd0, 32'h00000033);
        apply("post_read", 1'b1, 32'h01A80000, 32'h0,        12'h902, 32'h33, 32'h0, 5'd0, 32'h0);
        apply("same_reg",  1'b1, 32'h01084020, 32'h00000055, 12'h902,
              BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, 5'd0, 32'h00004020);
        apply("r8_after",  1'b1, 32'h01000000, 32'h0,        12'h902, 32'h55, 32'h0, 5'd0, 32'h0);
        @(posedge Clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
